// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI command sequencer: opcodes, one-hot state
// encoding and the default pad word.
package spi_seq_pkg;

  localparam logic [3:0]  OP_RD   = 4'h1;
  localparam logic [3:0]  OP_WR   = 4'h2;
  localparam logic [3:0]  OP_FIFO = 4'h3;

  localparam logic [15:0] PAD_WORD_DEFAULT = 16'hDEAD;

  // One-hot bit positions
  localparam int unsigned S_IDLE       = 0;
  localparam int unsigned S_RD_FETCH   = 1;
  localparam int unsigned S_RD_LOAD    = 2;
  localparam int unsigned S_RD_WAIT    = 3;
  localparam int unsigned S_WR_DATA    = 4;
  localparam int unsigned S_FIFO_FETCH = 5;
  localparam int unsigned S_FIFO_CAP   = 6;
  localparam int unsigned S_FIFO_HI_LD = 7;
  localparam int unsigned S_FIFO_HI    = 8;
  localparam int unsigned S_FIFO_LO    = 9;
  localparam int unsigned S_HDR_LD     = 10;
  localparam int unsigned S_HDR_WAIT   = 11;
  localparam int unsigned NUM_STATES   = 12;

  typedef logic [NUM_STATES-1:0] onehot_t;

  typedef enum logic [NUM_STATES-1:0] {
    IDLE       = onehot_t'(1 << S_IDLE),
    RD_FETCH   = onehot_t'(1 << S_RD_FETCH),
    RD_LOAD    = onehot_t'(1 << S_RD_LOAD),
    RD_WAIT    = onehot_t'(1 << S_RD_WAIT),
    WR_DATA    = onehot_t'(1 << S_WR_DATA),
    FIFO_FETCH = onehot_t'(1 << S_FIFO_FETCH),
    FIFO_CAP   = onehot_t'(1 << S_FIFO_CAP),
    FIFO_HI_LD = onehot_t'(1 << S_FIFO_HI_LD),
    FIFO_HI    = onehot_t'(1 << S_FIFO_HI),
    FIFO_LO    = onehot_t'(1 << S_FIFO_LO),
    HDR_LD     = onehot_t'(1 << S_HDR_LD),
    HDR_WAIT   = onehot_t'(1 << S_HDR_WAIT)
  } state_t;

  function automatic logic [3:0] cmd_op(input logic [7:0] b);
    return b[7:4];
  endfunction

endpackage

// File: rtl/spi_cmd_sequencer_sat_cnt.sv
// Saturating up-counter with synchronous active-high reset.
module sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold at all-ones
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: decodes RD / WR / FIFO command bytes and sequences
// register access, packetised FIFO readout and the transmit-byte load.
// Optional header byte (pk_sz) before FIFO data: define SPI_SEQ_HDR_EN.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter logic [15:0] PAD_WORD = PAD_WORD_DEFAULT,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  input  logic             tx_done,
  output logic             tx_load,
  output logic [7:0]       tx_byte,
  output logic [3:0]       reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_we,
  input  logic [7:0]       reg_rdata,
  output logic             fifo_rd,
  input  logic [15:0]      fifo_data,
  input  logic             fifo_empty,
  input  logic [7:0]       pk_sz,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] unf_cnt
);

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic [15:0] word, word_d;
  logic        from_fifo, from_fifo_d;
  logic [15:0] cap_word;

  logic        tx_load_d, reg_we_d, fifo_rd_d;
  logic [7:0]  tx_byte_d, reg_wdata_d;
  logic [3:0]  reg_addr_d;
  logic        err_inc, unf_inc;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      word      <= '0;
      from_fifo <= 1'b0;
      tx_load   <= 1'b0;
      tx_byte   <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      fifo_rd   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      word      <= word_d;
      from_fifo <= from_fifo_d;
      tx_load   <= tx_load_d;
      tx_byte   <= tx_byte_d;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
      reg_we    <= reg_we_d;
      fifo_rd   <= fifo_rd_d;
      busy      <= (state_d != IDLE);
    end
  end

  // Next-state and next-output decode; abort on cs_n overrides everything
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    word_d      = word;
    from_fifo_d = from_fifo;
    tx_byte_d   = tx_byte;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    tx_load_d   = 1'b0;
    reg_we_d    = 1'b0;
    fifo_rd_d   = 1'b0;
    err_inc     = 1'b0;
    unf_inc     = 1'b0;
    cap_word    = '0;

    if ((state != IDLE) && cs_n) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            reg_addr_d = rx_byte[3:0];
            case (cmd_op(rx_byte))
              OP_RD:   state_d = RD_FETCH;
              OP_WR:   state_d = WR_DATA;
              OP_FIFO: begin
                if (pk_sz != '0) begin
                  cnt_d = pk_sz;
`ifdef SPI_SEQ_HDR_EN
                  state_d = HDR_LD;
`else
                  state_d = FIFO_FETCH;
`endif
                end
              end
              default: err_inc = 1'b1;
            endcase
          end
        end
        RD_FETCH: state_d = RD_LOAD;
        RD_LOAD: begin
          tx_byte_d = reg_rdata;
          tx_load_d = 1'b1;
          state_d   = RD_WAIT;
        end
        RD_WAIT: begin
          if (tx_done) state_d = IDLE;
        end
        WR_DATA: begin
          if (rx_valid) begin
            reg_wdata_d = rx_byte;
            reg_we_d    = 1'b1;
            state_d     = IDLE;
          end
        end
`ifdef SPI_SEQ_HDR_EN
        HDR_LD: begin
          tx_byte_d = cnt;
          tx_load_d = 1'b1;
          state_d   = HDR_WAIT;
        end
        HDR_WAIT: begin
          if (tx_done) state_d = FIFO_FETCH;
        end
`endif
        FIFO_FETCH: begin
          if (!fifo_empty) begin
            fifo_rd_d   = 1'b1;
            from_fifo_d = 1'b1;
            state_d     = FIFO_CAP;
          end else begin
            word_d      = PAD_WORD;
            from_fifo_d = 1'b0;
            unf_inc     = 1'b1;
            state_d     = FIFO_HI_LD;
          end
        end
        // fifo_rd is registered, so fifo_data becomes valid only during
        // FIFO_HI_LD; the word is captured there rather than in FIFO_CAP.
        FIFO_CAP: state_d = FIFO_HI_LD;
        FIFO_HI_LD: begin
          cap_word  = from_fifo ? fifo_data : word;
          word_d    = cap_word;
          tx_byte_d = cap_word[15:8];
          tx_load_d = 1'b1;
          state_d   = FIFO_HI;
        end
        FIFO_HI: begin
          if (tx_done) begin
            tx_byte_d = word[7:0];
            tx_load_d = 1'b1;
            state_d   = FIFO_LO;
          end
        end
        FIFO_LO: begin
          if (tx_done) begin
            cnt_d   = cnt - 8'd1;
            state_d = (cnt == 8'd1) ? IDLE : FIFO_FETCH;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  sat_cnt #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_cnt)
  );

  sat_cnt #(.W(ERR_W)) u_unf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (unf_inc),
    .count (unf_cnt)
  );

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer: directed and randomized
// transactions against a transaction-level expectation model.
module tb_spi_cmd_sequencer;

  localparam logic [15:0] PAD = 16'hDEAD;
`ifdef SPI_SEQ_HDR_EN
  localparam int HDR_N = 1;
`else
  localparam int HDR_N = 0;
`endif

  logic        clk, rst, cs_n, rx_valid, tx_done;
  logic [7:0]  rx_byte, tx_byte, reg_wdata, reg_rdata, pk_sz;
  logic [3:0]  reg_addr;
  logic        tx_load, reg_we, fifo_rd, fifo_empty, busy;
  logic [15:0] fifo_data;
  logic [7:0]  err_cnt, unf_cnt;

  spi_cmd_sequencer #(.PAD_WORD(PAD), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_done(tx_done), .tx_load(tx_load), .tx_byte(tx_byte),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .pk_sz(pk_sz), .busy(busy),
    .err_cnt(err_cnt), .unf_cnt(unf_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file: synchronous read, one cycle after reg_addr
  logic [7:0] regs [16];
  always @(posedge clk) reg_rdata <= regs[reg_addr];

  // Sample FIFO: data valid the cycle after fifo_rd
  logic [15:0] fifo_mem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int fifo_rd_n = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      fifo_rd_n <= fifo_rd_n + 1;
    end
  end

  // Output monitor, sampled mid-cycle
  logic [7:0] tx_log [2048];
  logic [3:0] wa_log [256];
  logic [7:0] wd_log [256];
  int tx_n = 0;
  int wr_n = 0;
  int busy_cyc = 0;
  always @(negedge clk) begin
    if (tx_load) begin
      tx_log[tx_n] <= tx_byte;
      tx_n <= tx_n + 1;
    end
    if (reg_we) begin
      wa_log[wr_n] <= reg_addr;
      wd_log[wr_n] <= reg_wdata;
      wr_n <= wr_n + 1;
    end
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  // Shifter model: tx_done 1..4 cycles after each tx_load
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      while (tx_load) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  int err_exp = 0;
  int unf_exp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && busy !== 1'b0; i++) tick();
    check({tag, "_idle"}, 32'(busy), 32'(0));
  endtask

  task automatic check_tx(input string tag, input int start);
    int got;
    got = tx_n - start;
    check({tag, "_txcount"}, 32'(got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got; i++)
      check({tag, "_txbyte"}, 32'(tx_log[start + i]), 32'(exp_q[i]));
  endtask

  // Expected byte stream of one FIFO packet of p words with the given
  // FIFO contents (n words available); padding once the FIFO runs dry.
  logic [15:0] pushed [16];
  task automatic expect_fifo(input int p, input int n);
    logic [15:0] w;
    exp_q.delete();
    if (HDR_N != 0) exp_q.push_back(8'(p));
    for (int i = 0; i < p; i++) begin
      w = (i < n) ? pushed[i] : PAD;
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    if (p > n) unf_exp = unf_exp + (p - n);
    if (unf_exp > 255) unf_exp = 255;
  endtask

  initial begin : main
    int start, rd0, wr0, bz0, p, n, a;
    logic [7:0] d;

    rst = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_byte = '0; pk_sz = '0;
    for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
    repeat (4) @(posedge clk);
    #1;
    check("rst_tx_load",   32'(tx_load),   32'(0));
    check("rst_tx_byte",   32'(tx_byte),   32'(0));
    check("rst_reg_addr",  32'(reg_addr),  32'(0));
    check("rst_reg_wdata", 32'(reg_wdata), 32'(0));
    check("rst_reg_we",    32'(reg_we),    32'(0));
    check("rst_fifo_rd",   32'(fifo_rd),   32'(0));
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_err_cnt",   32'(err_cnt),   32'(0));
    check("rst_unf_cnt",   32'(unf_cnt),   32'(0));
    rst = 1'b0;
    tick();
    cs_n = 1'b0;
    tick();

    // Directed register read
    regs[5] = 8'h3C;
    start = tx_n;
    send_rx(8'h15);
    wait_idle("rd");
    exp_q = '{8'h3C};
    check_tx("rd", start);
    check("rd_addr", 32'(reg_addr), 32'(5));

    // Random register reads
    for (int t = 0; t < 8; t++) begin
      a = $urandom_range(0, 15);
      start = tx_n;
      send_rx({4'h1, 4'(a)});
      wait_idle("rrd");
      exp_q = '{regs[a]};
      check_tx("rrd", start);
    end

    // Directed and random register writes
    for (int t = 0; t < 7; t++) begin
      a = (t == 0) ? 10 : $urandom_range(0, 15);
      d = (t == 0) ? 8'h77 : 8'($urandom);
      start = tx_n; wr0 = wr_n;
      send_rx({4'h2, 4'(a)});
      repeat ($urandom_range(0, 3)) tick();
      send_rx(d);
      wait_idle("wr");
      tick();
      check("wr_count", 32'(wr_n - wr0), 32'(1));
      check("wr_addr",  32'(wa_log[wr0]), 32'(a));
      check("wr_data",  32'(wd_log[wr0]), 32'(d));
      check("wr_no_tx", 32'(tx_n - start), 32'(0));
    end

    // Directed FIFO packet, then underflow, then random packets
    for (int t = 0; t < 6; t++) begin
      if (t == 0) begin
        p = 3; n = 3;
        pushed[0] = 16'h1234; pushed[1] = 16'h5678; pushed[2] = 16'h9ABC;
      end else if (t == 1) begin
        p = 2; n = 0;
      end else begin
        p = $urandom_range(1, 5); n = $urandom_range(0, p + 1);
        for (int i = 0; i < n; i++) pushed[i] = 16'($urandom);
      end
      for (int i = 0; i < n; i++) begin
        fifo_mem[wr_ptr] = pushed[i];
        wr_ptr++;
      end
      pk_sz = 8'(p);
      start = tx_n; rd0 = fifo_rd_n;
      send_rx(8'h30);
      wait_idle("fifo");
      tick();
      expect_fifo(p, n);
      check_tx("fifo", start);
      check("fifo_reads", 32'(fifo_rd_n - rd0), 32'((n < p) ? n : p));
      check("unf_cnt", 32'(unf_cnt), 32'(unf_exp));
      wr_ptr = rd_ptr;
    end

    // FIFO command with zero packet size: nothing happens
    pk_sz = '0;
    start = tx_n; bz0 = busy_cyc;
    send_rx(8'h30);
    repeat (3) tick();
    check("pk0_no_tx",   32'(tx_n - start),    32'(0));
    check("pk0_no_busy", 32'(busy_cyc - bz0),  32'(0));
    check("pk0_err",     32'(err_cnt),         32'(err_exp));

    // Abort in WR_DATA coincident with the data byte
    wr0 = wr_n;
    send_rx(8'h2B);
    cs_n = 1'b1; rx_valid = 1'b1; rx_byte = 8'h55;
    tick();
    rx_valid = 1'b0;
    check("abort_wr_busy", 32'(busy), 32'(0));
    tick();
    cs_n = 1'b0;
    repeat (3) tick();
    check("abort_wr_noweq", 32'(wr_n - wr0), 32'(0));

    // Mid-FIFO abort after the first word has been sent
    pk_sz = 8'd3;
    for (int i = 0; i < 3; i++) begin
      fifo_mem[wr_ptr] = 16'($urandom);
      wr_ptr++;
    end
    start = tx_n; rd0 = fifo_rd_n;
    send_rx(8'h30);
    for (int i = 0; i < 200 && (tx_n - start) < HDR_N + 2; i++) tick();
    check("abort_fifo_reached", 32'(tx_n - start), 32'(HDR_N + 2));
    cs_n = 1'b1;
    repeat (2) tick();
    check("abort_fifo_busy", 32'(busy), 32'(0));
    repeat (10) tick();
    check("abort_fifo_reads", 32'(fifo_rd_n - rd0), 32'(1));
    check("abort_fifo_tx",    32'(tx_n - start),    32'(HDR_N + 2));
    cs_n = 1'b0;
    wr_ptr = rd_ptr;
    repeat (4) tick();

    // Unknown opcodes up to and past saturation
    start = tx_n; rd0 = fifo_rd_n; wr0 = wr_n; bz0 = busy_cyc;
    for (int i = 0; i < 260; i++) begin
      send_rx(8'hF0);
      err_exp = (err_exp < 255) ? err_exp + 1 : 255;
      if (i == 99) check("err_cnt_100", 32'(err_cnt), 32'(err_exp));
    end
    tick();
    check("err_cnt_sat",  32'(err_cnt),         32'(err_exp));
    check("unk_no_tx",    32'(tx_n - start),    32'(0));
    check("unk_no_rd",    32'(fifo_rd_n - rd0), 32'(0));
    check("unk_no_wr",    32'(wr_n - wr0),      32'(0));
    check("unk_no_busy",  32'(busy_cyc - bz0),  32'(0));
    check("unk_unf_hold", 32'(unf_cnt),         32'(unf_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
